apb_req_arbiter: RTL

- Round-robin arbiter that shares one APB master port between NUM_REQ requesters. Each requester uses a simple valid/ready command interface and receives a one-cycle response pulse.
- Sits between the bus masters (CPU bridge, DMA, debug) and the APB peripheral fabric, e.g. the UART register block.
- Sequences the APB protocol: setup, access, then wait for pready.

---
 rtl/apb_req_arbiter.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one APB master among NUM_REQ valid/ready requesters; pready watchdog under APB_REQ_ARBITER_TIMEOUT_EN.
// Accept at T -> psel T+1, penable T+2, rsp pulse T+3 plus wait states; one transfer in flight, others held off by req_ready_o.
`ifndef DEFAULT_ADDR_WIDTH
`define DEFAULT_ADDR_WIDTH 32
`endif
`ifndef DEFAULT_DATA_WIDTH
`define DEFAULT_DATA_WIDTH 32
`endif

module apb_req_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_WIDTH     = `DEFAULT_ADDR_WIDTH,
  parameter int DATA_WIDTH     = `DEFAULT_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                            clk_i,
  input  logic                            srst_i,
  input  logic [NUM_REQ-1:0]              req_valid_i,
  output logic [NUM_REQ-1:0]              req_ready_o,
  input  logic [NUM_REQ-1:0]              req_write_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata_i,
  input  logic [NUM_REQ*DATA_WIDTH/8-1:0] req_strb_i,
  output logic [NUM_REQ-1:0]              rsp_valid_o,
  output logic [DATA_WIDTH-1:0]           rsp_rdata_o,
  output logic                            rsp_slverr_o,
  output logic                            psel_o,
  output logic                            penable_o,
  output logic                            pwrite_o,
  output logic [ADDR_WIDTH-1:0]           paddr_o,
  output logic [DATA_WIDTH-1:0]           pwdata_o,
  output logic [DATA_WIDTH/8-1:0]         pstrb_o,
  input  logic                            pready_i,
  input  logic                            pslverr_i,
  input  logic [DATA_WIDTH-1:0]           prdata_i
);

  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int STRB_W = DATA_WIDTH / 8;

  if (NUM_REQ < 2 || NUM_REQ > 8 || (DATA_WIDTH % 8) != 0 || TIMEOUT_CYCLES < 2) begin : g_cfg_err
    $error("apb_req_arbiter: unsupported parameter set");
  end

  typedef struct packed {
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_W-1:0]     strb;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t           state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] gnt_q;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_found;
  logic [NUM_REQ-1:0] gnt_oh;
  logic [NUM_REQ-1:0] gnt_q_oh;
  cmd_t             cmd_q;
  cmd_t             cmd_sel;

`ifdef APB_REQ_ARBITER_TIMEOUT_EN
  localparam int TO_LOG = $clog2(TIMEOUT_CYCLES);
  localparam int TO_W   = (TO_LOG < 8) ? 8 : ((TO_LOG > 32) ? 32 : TO_LOG);
  logic [TO_W-1:0] wd_cnt;
`endif

  // Index ptr+off folded back into 0..NUM_REQ-1 (works for non-power-of-two NUM_REQ).
  function automatic logic [IDX_W-1:0] wrap_idx(input int base, input int off);
    int s;
    s = base + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDX_W'(s);
  endfunction

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!gnt_found && req_valid_i[wrap_idx(int'(ptr), i)]) begin
        gnt_found = 1'b1;
        gnt_idx   = wrap_idx(int'(ptr), i);
      end
    end
  end

  always_comb begin
    cmd_sel.write = req_write_i[gnt_idx];
    cmd_sel.addr  = req_addr_i[gnt_idx*ADDR_WIDTH +: ADDR_WIDTH];
    cmd_sel.wdata = req_wdata_i[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
    cmd_sel.strb  = req_strb_i[gnt_idx*STRB_W +: STRB_W];
  end

  assign gnt_oh      = {{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_idx;
  assign gnt_q_oh    = {{(NUM_REQ-1){1'b0}}, 1'b1} << gnt_q;
  assign req_ready_o = (state == IDLE && gnt_found) ? gnt_oh : '0;

  assign pwrite_o = cmd_q.write;
  assign paddr_o  = cmd_q.addr;
  assign pwdata_o = cmd_q.wdata;
  assign pstrb_o  = cmd_q.strb;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state        <= IDLE;
      ptr          <= '0;
      gnt_q        <= '0;
      cmd_q        <= '0;
      psel_o       <= 1'b0;
      penable_o    <= 1'b0;
      rsp_valid_o  <= '0;
      rsp_rdata_o  <= '0;
      rsp_slverr_o <= 1'b0;
`ifdef APB_REQ_ARBITER_TIMEOUT_EN
      wd_cnt       <= '0;
`endif
    end else begin
      rsp_valid_o <= '0;
      case (state)
        IDLE: begin
          if (gnt_found) begin
            cmd_q  <= cmd_sel;
            gnt_q  <= gnt_idx;
            ptr    <= wrap_idx(int'(gnt_idx), 1);
            psel_o <= 1'b1;
            state  <= SETUP;
          end
        end
        SETUP: begin
          penable_o <= 1'b1;
          state     <= ACCESS;
`ifdef APB_REQ_ARBITER_TIMEOUT_EN
          wd_cnt    <= '0;
`endif
        end
        ACCESS: begin
          if (pready_i) begin
            psel_o       <= 1'b0;
            penable_o    <= 1'b0;
            rsp_valid_o  <= gnt_q_oh;
            rsp_rdata_o  <= prdata_i;
            rsp_slverr_o <= pslverr_i;
            state        <= IDLE;
          end
`ifdef APB_REQ_ARBITER_TIMEOUT_EN
          // Stuck slave: complete the requester with an error instead of hanging the bus.
          else if (wd_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
            psel_o       <= 1'b0;
            penable_o    <= 1'b0;
            rsp_valid_o  <= gnt_q_oh;
            rsp_rdata_o  <= '0;
            rsp_slverr_o <= 1'b1;
            state        <= IDLE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
